freq_count_latch: RTL and testbench

Measurement stage directly downstream of the gate/latch/reset sequencer in the frequency meter. Counts rising edges of the unknown input while the gate window is open, accumulates them as packed BCD, and on the latch strobe transfers the count to a held display register. The display driver reads the held register.

---
 rtl/freq_cnt_pkg.sv | 24 ++
 rtl/freq_count_latch_if.sv | 39 +++
 rtl/freq_count_latch_bcd_digit.sv | 28 ++
 rtl/freq_count_latch.sv | 198 +++++++++++++++++++
 tb/tb_freq_count_latch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_cnt_pkg.sv
// freq_cnt_pkg: shared types and constants for the frequency-meter
// measurement stage (FSM state encoding, BCD digit type, digit limit).
package freq_cnt_pkg;

    // Measurement FSM states. WAIT_CLR is the reset encoding (all zeros).
    typedef enum logic [1:0] {
        WAIT_CLR = 2'd0,
        ARMED    = 2'd1,
        COUNT    = 2'd2,
        DONE     = 2'd3
    } fsm_state_t;

    // One packed-BCD decade.
    typedef logic [3:0] bcd_digit_t;

    // Largest legal value of a decade.
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Next value of a decade on increment: 9 wraps to 0.
    function automatic bcd_digit_t bcd_next(input bcd_digit_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/freq_count_latch_if.sv
// freq_count_latch_if: sequencer-side inputs, display-side held outputs and
// debug observation points of the measurement stage.
//
// Handshake: valid is a one-cycle strobe, high on the cycle bcd_out and
// overflow have just been updated. There is no ready; the display side must
// take the data whenever it likes, since bcd_out holds until the next latch.
interface freq_count_latch_if #(
    parameter int DIGITS = 8
);
    import freq_cnt_pkg::*;

    // Sequencer / signal side
    logic                  sig_in;
    logic                  gate;
    logic                  latch;
    logic                  cnt_clr;

    // Display side
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
    logic                  valid;

    // Debug: FSM state, working counter, and a pulse when the counter
    // wraps past all-9s.
    fsm_state_t            state_dbg;
    logic [4*DIGITS-1:0]   cnt_dbg;
    logic                  wrap_dbg;

    modport master (
        output sig_in, gate, latch, cnt_clr,
        input  bcd_out, overflow, valid, state_dbg, cnt_dbg, wrap_dbg
    );

    modport slave (
        input  sig_in, gate, latch, cnt_clr,
        output bcd_out, overflow, valid, state_dbg, cnt_dbg, wrap_dbg
    );

endinterface

// File: rtl/freq_count_latch_bcd_digit.sv
// bcd_digit: one decade of the working BCD counter. Clear wins over
// increment; carry tells the next decade to step on a 9 -> 0 wrap.
module bcd_digit
    import freq_cnt_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t q,
    output logic       carry
);

    // Decade register: clear has priority over increment.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= bcd_next(q);
        end
    end

    // Carry is combinational so a whole ripple of 9s steps in one cycle.
    assign carry = inc && (q == BCD_MAX);

endmodule

// File: rtl/freq_count_latch.sv
// freq_count_latch: counts synchronised rising edges of sig_in while the
// gate window is open, as packed BCD, and on a latch strobe in DONE copies
// the count to the held display register with a one-cycle valid pulse.
//
// Optional feature macro: FREQ_CNT_OVERFLOW_EN. When defined, a sticky
// working overflow flag sets on the increment past all-9s and is carried to
// overflow at latch. When undefined, overflow is tied low and the counter
// wraps silently.
module freq_count_latch
    import freq_cnt_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    freq_count_latch_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    // Bit positions of the four asynchronous inputs in the sync bundle.
    localparam int B_SIG   = 0;
    localparam int B_GATE  = 1;
    localparam int B_LATCH = 2;
    localparam int B_CLR   = 3;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detectors
    // ------------------------------------------------------------------
    logic [3:0] in_raw;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] prev_q;
    logic [3:0] sync_out;
    logic [3:0] rise;

    assign in_raw   = {bus.cnt_clr, bus.latch, bus.gate, bus.sig_in};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one flop of history for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'd0;
            end
            prev_q <= 4'd0;
        end else begin
            sync_q[0] <= in_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_out;
        end
    end

    assign rise = sync_out & ~prev_q;

    logic sig_rise;
    logic gate_rise;
    logic gate_fall;
    logic latch_rise;
    logic clr_rise;

    assign sig_rise   = rise[B_SIG];
    assign gate_rise  = rise[B_GATE];
    assign gate_fall  = prev_q[B_GATE] & ~sync_out[B_GATE];
    assign latch_rise = rise[B_LATCH];
    assign clr_rise   = rise[B_CLR];

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    fsm_state_t state_q;
    fsm_state_t state_d;
    logic       count_en;
    logic       latch_fire;

    // State register; reset discards any measurement in progress.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a clear edge always re-arms, even when it coincides with
    // the latch edge in DONE (the latch still sees the pre-clear count).
    always_comb begin
        state_d = state_q;
        if (clr_rise) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                WAIT_CLR: state_d = WAIT_CLR;
                ARMED:    if (gate_rise)  state_d = COUNT;
                COUNT:    if (gate_fall)  state_d = DONE;
                DONE:     if (latch_rise) state_d = WAIT_CLR;
                default:  state_d = WAIT_CLR;
            endcase
        end
    end

    // FSM outputs: an edge on the same cycle as the gate falling edge is
    // still counted because the state is still COUNT on that cycle.
    always_comb begin
        count_en   = 1'b0;
        latch_fire = 1'b0;
        if (state_q == COUNT) begin
            count_en = sig_rise;
        end
        if (state_q == DONE) begin
            latch_fire = latch_rise;
        end
    end

    // ------------------------------------------------------------------
    // Working BCD counter, one decade per instance
    // ------------------------------------------------------------------
    logic [W-1:0]      cnt_q;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] carry;
    logic              wrap;

    assign inc[0] = count_en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_in (clk_in),
            .rst_n  (rst_n),
            .clr    (clr_rise),
            .inc    (inc[g]),
            .q      (cnt_q[4*g +: 4]),
            .carry  (carry[g])
        );
        if (g < DIGITS - 1) begin : g_chain
            assign inc[g+1] = carry[g];
        end
    end

    // Carry out of the top decade: the increment past all-9s.
    assign wrap = carry[DIGITS-1];

    // ------------------------------------------------------------------
    // Held display register
    // ------------------------------------------------------------------
    logic [W-1:0] bcd_q;
    logic         valid_q;

    // Capture on latch in DONE; unaffected by clears or counting otherwise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= latch_fire;
            if (latch_fire) begin
                bcd_q <= cnt_q;
            end
        end
    end

`ifdef FREQ_CNT_OVERFLOW_EN
    logic ovf_work_q;
    logic ovf_q;

    // Sticky working overflow: cleared by a clear edge, set on wrap.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ovf_work_q <= 1'b0;
        end else if (clr_rise) begin
            ovf_work_q <= 1'b0;
        end else if (wrap) begin
            ovf_work_q <= 1'b1;
        end
    end

    // Held overflow follows the working flag at latch time only.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (latch_fire) begin
            ovf_q <= ovf_work_q;
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.bcd_out   = bcd_q;
    assign bus.valid     = valid_q;
    assign bus.state_dbg = state_q;
    assign bus.cnt_dbg   = cnt_q;
    assign bus.wrap_dbg  = wrap;

endmodule

// File: tb/tb_freq_count_latch.sv
// tb_freq_count_latch: table-driven measurement cycles on an 8-decade
// instance, a 2-decade instance sharing the same inputs for the wrap case,
// and hand-written sequences for reset mid-count and latch+clear together.
module tb_freq_count_latch;
    import freq_cnt_pkg::*;

    localparam int W = 32;

`ifdef FREQ_CNT_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_n;

    always #5 clk_in = ~clk_in;

    freq_count_latch_if #(.DIGITS(8)) bus ();
    freq_count_latch_if #(.DIGITS(2)) bus2 ();

    assign bus2.sig_in  = bus.sig_in;
    assign bus2.gate    = bus.gate;
    assign bus2.latch   = bus.latch;
    assign bus2.cnt_clr = bus.cnt_clr;

    freq_count_latch #(.DIGITS(8), .SYNC_STAGES(2)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    freq_count_latch #(.DIGITS(2), .SYNC_STAGES(2)) dut2 (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus2.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    logic [W-1:0] held_bcd;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Every valid pulse must match the oldest expected {overflow, bcd}.
    always @(negedge clk_in) begin
        if (rst_n && bus.valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL spurious_valid: got valid with bcd=%h ovf=%b, required no pulse",
                         bus.bcd_out, bus.overflow);
            end else begin
                exp_v = exp_q.pop_front();
                if ({bus.overflow, bus.bcd_out} !== exp_v) begin
                    n_errors++;
                    $display("FAIL latched_value: got ovf=%b bcd=%h, required ovf=%b bcd=%h",
                             bus.overflow, bus.bcd_out, exp_v[W], exp_v[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse_sig(input int n);
        for (int i = 0; i < n; i++) begin
            bus.sig_in = 1'b1;
            cycles(2);
            bus.sig_in = 1'b0;
            cycles(2);
        end
    endtask

    task automatic clr_pulse();
        bus.cnt_clr = 1'b1;
        cycles(2);
        bus.cnt_clr = 1'b0;
        cycles(6);
    endtask

    task automatic latch_pulse();
        bus.latch = 1'b1;
        cycles(2);
        bus.latch = 1'b0;
        cycles(6);
    endtask

    task automatic run_window(input int n_pre, input int n_in, input int n_post);
        pulse_sig(n_pre);
        bus.gate = 1'b1;
        cycles(6);
        pulse_sig(n_in);
        cycles(4);
        bus.gate = 1'b0;
        cycles(6);
        pulse_sig(n_post);
    endtask

    task automatic expect_latch(input logic [W-1:0] bcd, input logic ovf);
        exp_q.push_back({ovf, bcd});
        held_bcd = bcd;
    endtask

    // Bounded wait for all expected valid pulses to arrive.
    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            cycles(1);
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           do_clr;
        int           n_pre;
        int           n_in;
        int           n_post;
        bit           exp_valid;
        logic [W-1:0] exp_bcd;
        bit           chk_narrow;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 0, 10, 0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 0, 1234, 0, 1'b1, 32'h0000_1234, 1'b0};
        vecs[2] = '{1'b1, 50, 7, 50, 1'b1, 32'h0000_0007, 1'b0};
        vecs[3] = '{1'b1, 0, 100, 0, 1'b1, 32'h0000_0100, 1'b1};
        vecs[4] = '{1'b1, 0, 0, 0, 1'b1, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 3, 19, 2, 1'b1, 32'h0000_0019, 1'b0};

        bus.sig_in  = 1'b0;
        bus.gate    = 1'b0;
        bus.latch   = 1'b0;
        bus.cnt_clr = 1'b0;
        held_bcd    = '0;
        rst_n       = 1'b0;
        cycles(3);
        check("reset_bcd_out", 64'(bus.bcd_out), 64'd0);
        check("reset_overflow", 64'(bus.overflow), 64'd0);
        check("reset_valid", 64'(bus.valid), 64'd0);
        check("reset_state", 64'(bus.state_dbg), 64'(WAIT_CLR));
        check("reset_counter", 64'(bus.cnt_dbg), 64'd0);
        rst_n = 1'b1;
        cycles(3);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_clr) clr_pulse();
            run_window(vecs[v].n_pre, vecs[v].n_in, vecs[v].n_post);
            if (vecs[v].exp_valid) expect_latch(vecs[v].exp_bcd, 1'b0);
            latch_pulse();
            drain($sformatf("vec%0d_valid_seen", v));
            check($sformatf("vec%0d_bcd_held", v), 64'(bus.bcd_out), 64'(held_bcd));
            if (!vecs[v].exp_valid) begin
                check($sformatf("vec%0d_state_wait_clr", v), 64'(bus.state_dbg), 64'(WAIT_CLR));
            end
            if (vecs[v].chk_narrow) begin
                check("narrow_wrap_bcd", 64'(bus2.bcd_out), 64'h00);
                check("narrow_overflow", 64'(bus2.overflow), 64'(OVF_EN));
            end
        end

        // Clears and counting between latches leave the held value alone.
        clr_pulse();
        bus.gate = 1'b1;
        cycles(6);
        pulse_sig(500);
        check("pre_reset_counter", 64'(bus.cnt_dbg), 64'h500);
        check("pre_reset_held", 64'(bus.bcd_out), 64'(held_bcd));

        // Reset mid-COUNT clears everything asynchronously.
        rst_n = 1'b0;
        #1;
        check("midrst_bcd_out", 64'(bus.bcd_out), 64'd0);
        check("midrst_overflow", 64'(bus.overflow), 64'd0);
        check("midrst_valid", 64'(bus.valid), 64'd0);
        check("midrst_counter", 64'(bus.cnt_dbg), 64'd0);
        check("midrst_state", 64'(bus.state_dbg), 64'(WAIT_CLR));
        bus.gate = 1'b0;
        held_bcd = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        clr_pulse();
        run_window(0, 3, 0);
        expect_latch(32'h0000_0003, 1'b0);
        latch_pulse();
        drain("post_reset_valid_seen");
        check("post_reset_bcd", 64'(bus.bcd_out), 64'h3);

        // Latch and clear edges on the same cycle in DONE.
        clr_pulse();
        run_window(0, 42, 0);
        check("done_counter_42", 64'(bus.cnt_dbg), 64'h42);
        check("done_state", 64'(bus.state_dbg), 64'(DONE));
        expect_latch(32'h0000_0042, 1'b0);
        bus.latch   = 1'b1;
        bus.cnt_clr = 1'b1;
        cycles(2);
        bus.latch   = 1'b0;
        bus.cnt_clr = 1'b0;
        cycles(6);
        drain("latch_clr_valid_seen");
        check("latch_clr_bcd", 64'(bus.bcd_out), 64'h42);
        check("latch_clr_state", 64'(bus.state_dbg), 64'(ARMED));
        check("latch_clr_counter", 64'(bus.cnt_dbg), 64'd0);

        // Already ARMED: a new window counts without another clear.
        run_window(0, 5, 0);
        expect_latch(32'h0000_0005, 1'b0);
        latch_pulse();
        drain("rearm_valid_seen");
        check("rearm_bcd", 64'(bus.bcd_out), 64'h5);

        cycles(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
